// File: rtl/uart_line_echo_buf_if.sv
// Handshake bundle between uart_ctrler and the line echo buffer.
// master = uart_ctrler side, slave = echo buffer.
interface uart_line_echo_buf_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  rx_done;
  logic [7:0]            rx_byte;
  logic                  tx_done;
  logic                  tx_trigger;
  logic [7:0]            tx_byte;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  overflow;
  logic                  busy;

  modport master (
    output rx_done,
    output rx_byte,
    output tx_done,
    input  tx_trigger,
    input  tx_byte,
    input  fifo_level,
    input  overflow,
    input  busy
  );

  modport slave (
    input  rx_done,
    input  rx_byte,
    input  tx_done,
    output tx_trigger,
    output tx_byte,
    output fifo_level,
    output overflow,
    output busy
  );
endinterface

// File: rtl/uart_line_echo_buf.sv
// Line-buffered echo: collects rx bytes in a FIFO and replays a whole
// line through the tx handshake once a terminator arrives or it fills.
module uart_line_echo_buf #(
  parameter int         DEPTH_LOG2    = 4,
  parameter logic [7:0] EOL_BYTE      = 8'h0D,
  parameter bit         CONVERT_UPPER = 1'b0
) (
  input logic                 sclk,
  input logic                 rst,
  uart_line_echo_buf_if.slave bus
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic [DEPTH_LOG2:0]   eol_cnt;
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [7:0]            tx_q;
  logic                  ovf;
  logic [7:0]            head;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  push_eol;
  logic                  pop_eol;

  function automatic logic [7:0] conv(input logic [7:0] b);
    if (CONVERT_UPPER && b >= 8'h61 && b <= 8'h7A)
      return b - 8'h20;
    return b;
  endfunction

  assign head     = mem[rd_ptr];
  assign full     = (level == FULL_LVL);
  assign pop      = (state == LOAD);
  // a pop in the same cycle frees the slot a full FIFO needs
  assign push     = bus.rx_done && (!full || pop);
  assign push_eol = push && (bus.rx_byte == EOL_BYTE);
  assign pop_eol  = pop && (head == EOL_BYTE);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT:
        if (eol_cnt != '0 || full)
          state_nxt = LOAD;
      LOAD:
        state_nxt = SEND;
      SEND:
        state_nxt = WAIT;
      WAIT:
        if (bus.tx_done)
          state_nxt = (level_nxt != '0) ? LOAD : COLLECT;
      default:
        state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (push)
      mem[wr_ptr] <= bus.rx_byte;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state   <= COLLECT;
      level   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      eol_cnt <= '0;
      tx_q    <= 8'h00;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        tx_q   <= conv(head);
      end
      case ({push_eol, pop_eol})
        2'b10:   eol_cnt <= eol_cnt + 1'b1;
        2'b01:   eol_cnt <= eol_cnt - 1'b1;
        default: eol_cnt <= eol_cnt;
      endcase
      if (bus.rx_done && full && !pop)
        ovf <= 1'b1;
    end
  end

  assign bus.tx_trigger = (state == SEND);
  assign bus.tx_byte    = tx_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf;
  assign bus.busy       = (state != COLLECT);

endmodule

// File: tb/tb_uart_line_echo_buf.sv
// Self-checking bench for uart_line_echo_buf: directed sequences,
// a conversion vector table and a randomized scoreboard run.
module tb_uart_line_echo_buf;

  logic sclk;
  logic rst;
  int   cycle;
  int   n_pass;
  int   n_tot;

  uart_line_echo_buf_if #(.DEPTH_LOG2(4)) b0 ();
  uart_line_echo_buf_if #(.DEPTH_LOG2(4)) b1 ();

  uart_line_echo_buf #(
    .DEPTH_LOG2(4), .EOL_BYTE(8'h0D), .CONVERT_UPPER(1'b0)
  ) dut0 (.sclk(sclk), .rst(rst), .bus(b0));

  uart_line_echo_buf #(
    .DEPTH_LOG2(4), .EOL_BYTE(8'h0D), .CONVERT_UPPER(1'b1)
  ) dut1 (.sclk(sclk), .rst(rst), .bus(b1));

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
  } vec_t;

  logic [7:0] got0 [$];
  int         tcyc [$];
  logic [7:0] exp_q [$];
  bit         pend;
  bit         resp_en;
  int         resp_dly;
  int         cnt;
  logic [7:0] last;

  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  always @(posedge sclk) cycle <= cycle + 1;

  task automatic clk1();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push0(input logic [7:0] b);
    b0.rx_done = 1'b1;
    b0.rx_byte = b;
    clk1();
    b0.rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    pend = 1'b0;
    got0.delete();
    tcyc.delete();
  endtask

  task automatic wait_trig(input int n, input string nm);
    int k;
    k = 0;
    while (got0.size() < n && k < 300) begin
      clk1();
      k++;
    end
    chk(nm, got0.size() >= n, 1);
  endtask

  task automatic wait_n(input int n, input string nm, output int gaps);
    bit done;
    done = 1'b0;
    gaps = 0;
    for (int k = 0; k < 800 && !done; k++) begin
      if (got0.size() >= n && !pend && !b0.busy) done = 1'b1;
      else begin
        if (!b0.busy) gaps++;
        clk1();
      end
    end
    chk(nm, done, 1);
  endtask

  // tx side of uart_ctrler for dut0: logs triggers, answers with tx_done
  initial begin
    forever begin
      clk1();
      if (resp_en) b0.tx_done = 1'b0;
      if (b0.tx_trigger) begin
        got0.push_back(b0.tx_byte);
        tcyc.push_back(cycle);
        chk("one_outstanding", pend, 0);
        pend = 1'b1;
        last = b0.tx_byte;
        cnt = (resp_dly != 0) ? resp_dly : int'($urandom_range(1, 12));
      end else if (pend && resp_en) begin
        cnt--;
        if (cnt <= 0) begin
          chk("tx_byte_held", b0.tx_byte, last);
          b0.tx_done = 1'b1;
          pend = 1'b0;
        end
      end
    end
  end

  initial begin
    vec_t       tbl [7];
    logic [7:0] e1 [3];
    logic [7:0] e5 [5];
    int         rxc;
    int         gaps;
    int         n0;
    int         k;
    logic [7:0] g;
    logic [7:0] b;
    bit         done;

    tbl[0] = '{8'h61, 8'h41};
    tbl[1] = '{8'h5A, 8'h5A};
    tbl[2] = '{8'h7B, 8'h7B};
    tbl[3] = '{8'h60, 8'h60};
    tbl[4] = '{8'h7A, 8'h5A};
    tbl[5] = '{8'h41, 8'h41};
    tbl[6] = '{8'h0D, 8'h0D};
    e1 = '{8'h68, 8'h69, 8'h0D};
    e5 = '{8'h61, 8'h62, 8'h0D, 8'h63, 8'h0D};

    n_pass = 0;
    n_tot = 0;
    pend = 1'b0;
    resp_en = 1'b0;
    resp_dly = 10;
    b0.rx_done = 1'b0; b0.rx_byte = 8'h00; b0.tx_done = 1'b0;
    b1.rx_done = 1'b0; b1.rx_byte = 8'h00; b1.tx_done = 1'b0;
    rst = 1'b1;
    clk1();
    clk1();
    chk("rst_trigger", b0.tx_trigger, 0);
    chk("rst_tx_byte", b0.tx_byte, 0);
    chk("rst_level", b0.fifo_level, 0);
    chk("rst_overflow", b0.overflow, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_busy_u", b1.busy, 0);
    rst = 1'b0;
    clk1();

    // "hi" + CR, tx_done 10 cycles after each trigger
    resp_en = 1'b1;
    resp_dly = 10;
    push0(8'h68);
    push0(8'h69);
    rxc = cycle;
    push0(8'h0D);
    wait_n(3, "t1_drain", gaps);
    chk("t1_count", got0.size(), 3);
    for (int i = 0; i < 3 && i < got0.size(); i++)
      chk("t1_byte", got0[i], e1[i]);
    if (tcyc.size() >= 2) begin
      chk("t1_latency", tcyc[0] - rxc, 3);
      chk("t1_b2b", tcyc[1] - tcyc[0], 12);
    end
    chk("t1_level", b0.fifo_level, 0);
    chk("t1_busy", b0.busy, 0);

    // upper-case conversion table on dut1
    foreach (tbl[i]) begin
      b1.rx_done = 1'b1;
      b1.rx_byte = tbl[i].rx;
      clk1();
    end
    b1.rx_done = 1'b0;
    foreach (tbl[i]) begin
      k = 0;
      while (!b1.tx_trigger && k < 50) begin
        clk1();
        k++;
      end
      chk("upper_trig", b1.tx_trigger, 1);
      chk("upper_byte", b1.tx_byte, tbl[i].tx);
      repeat (3) clk1();
      b1.tx_done = 1'b1;
      clk1();
      b1.tx_done = 1'b0;
    end
    repeat (3) clk1();
    chk("upper_idle", b1.busy, 0);

    // full FIFO without terminator starts a drain; push during pop kept
    do_reset();
    resp_dly = 3;
    for (int i = 0; i < 15; i++) push0(8'h40 + 8'(i));
    repeat (4) clk1();
    chk("t2_no_drain_busy", b0.busy, 0);
    chk("t2_level15", b0.fifo_level, 15);
    push0(8'h4F);
    chk("t2_level16", b0.fifo_level, 16);
    clk1();
    push0(8'h50);
    chk("t2_push_pop_lvl", b0.fifo_level, 16);
    chk("t2_no_ovf", b0.overflow, 0);
    wait_n(17, "t2_drain", gaps);
    chk("t2_count", got0.size(), 17);
    for (int i = 0; i < 17 && i < got0.size(); i++)
      chk("t2_byte", got0[i], 8'h40 + 8'(i));
    chk("t2_ovf_end", b0.overflow, 0);

    // overflow while tx_done is withheld
    do_reset();
    resp_en = 1'b0;
    resp_dly = 2;
    for (int i = 0; i < 17; i++) push0(8'h20 + 8'(i));
    chk("t3_ovf", b0.overflow, 1);
    repeat (4) clk1();
    chk("t3_level", b0.fifo_level, 15);
    chk("t3_one_sent", got0.size(), 1);
    resp_en = 1'b1;
    wait_n(16, "t3_drain", gaps);
    chk("t3_count", got0.size(), 16);
    for (int i = 0; i < 16 && i < got0.size(); i++)
      chk("t3_byte", got0[i], 8'h20 + 8'(i));
    chk("t3_ovf_sticky", b0.overflow, 1);

    // bytes appended mid-drain go out in the same drain
    do_reset();
    chk("t5_ovf_rst", b0.overflow, 0);
    resp_dly = 10;
    push0(8'h61);
    push0(8'h62);
    push0(8'h0D);
    wait_trig(1, "t5_first");
    push0(8'h63);
    push0(8'h0D);
    wait_n(5, "t5_drain", gaps);
    chk("t5_single_drain", gaps, 0);
    chk("t5_count", got0.size(), 5);
    for (int i = 0; i < 5 && i < got0.size(); i++)
      chk("t5_byte", got0[i], e5[i]);

    // reset in WAIT with bytes left, then a stray tx_done
    do_reset();
    resp_dly = 10;
    push0(8'h61);
    push0(8'h62);
    push0(8'h63);
    push0(8'h0D);
    wait_trig(1, "t6_first");
    resp_en = 1'b0;
    clk1();
    clk1();
    chk("t6_level3", b0.fifo_level, 3);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    pend = 1'b0;
    chk("t6_level", b0.fifo_level, 0);
    chk("t6_busy", b0.busy, 0);
    chk("t6_trigger", b0.tx_trigger, 0);
    n0 = got0.size();
    b0.tx_done = 1'b1;
    clk1();
    b0.tx_done = 1'b0;
    repeat (6) clk1();
    chk("t6_stray", got0.size(), n0);
    chk("t6_busy_after", b0.busy, 0);

    // random traffic against an in-order line scoreboard
    do_reset();
    resp_en = 1'b1;
    resp_dly = 0;
    exp_q.delete();
    for (int c = 0; c < 2500; c++) begin
      while (got0.size() > 0) begin
        g = got0.pop_front();
        chk("rnd_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("rnd_byte", g, exp_q.pop_front());
      end
      b0.rx_done = 1'b0;
      if (exp_q.size() < 15 && $urandom_range(0, 2) == 0) begin
        b = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
        b0.rx_done = 1'b1;
        b0.rx_byte = b;
        exp_q.push_back(b);
      end
      clk1();
    end
    b0.rx_done = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      while (got0.size() > 0) begin
        g = got0.pop_front();
        chk("rnd_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("rnd_byte", g, exp_q.pop_front());
      end
      if (exp_q.size() < 15 && exp_q.size() > 0 &&
          exp_q[exp_q.size()-1] != 8'h0D && !b0.rx_done) begin
        b0.rx_done = 1'b1;
        b0.rx_byte = 8'h0D;
        exp_q.push_back(8'h0D);
      end else b0.rx_done = 1'b0;
      if (exp_q.size() == 0 && !pend && !b0.busy && !b0.rx_done) done = 1'b1;
      else clk1();
    end
    b0.rx_done = 1'b0;
    chk("rnd_drained", done, 1);
    chk("rnd_left", exp_q.size(), 0);
    chk("rnd_ovf", b0.overflow, 0);
    chk("rnd_level", b0.fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
